// File: rtl/countdown_timer_pkg.sv
// Shared types, defaults and BCD helpers for the mm:ss:cc countdown timer.
package countdown_timer_pkg;

  localparam int unsigned TICK_DIV_DEF    = 500000;
  localparam int unsigned BLINK_TICKS_DEF = 25;
  localparam int unsigned SEG_W           = 7;
  localparam int unsigned DIGITS          = 6;
  localparam int unsigned COUNT_W         = 4 * DIGITS;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;

  // Largest legal value of each BCD digit: min hi/lo, sec hi/lo, cs hi/lo
  localparam logic [COUNT_W-1:0] DIGIT_MAX = 24'h59_59_99;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [COUNT_W-1:0] clamp_preset(input logic [COUNT_W-1:0] p);
    logic [COUNT_W-1:0] r;
    r = p;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (p[4*i +: 4] > DIGIT_MAX[4*i +: 4]) r[4*i +: 4] = DIGIT_MAX[4*i +: 4];
    end
    return r;
  endfunction

  // One-centisecond decrement; a zero digit wraps to its max and borrows upward
  function automatic logic [COUNT_W-1:0] bcd_dec(input logic [COUNT_W-1:0] c);
    logic [COUNT_W-1:0] r;
    logic               borrow;
    r      = c;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (c[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = DIGIT_MAX[4*i +: 4];
        end else begin
          r[4*i +: 4] = c[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_sevenseg.sv
// BCD digit to active-low {g..a} segment encoder; non-BCD codes blank the digit.
module countdown_timer_sevenseg
  import countdown_timer_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = 7'b100_0000;
      4'd1: seg_o = 7'b111_1001;
      4'd2: seg_o = 7'b010_0100;
      4'd3: seg_o = 7'b011_0000;
      4'd4: seg_o = 7'b001_1001;
      4'd5: seg_o = 7'b001_0010;
      4'd6: seg_o = 7'b000_0010;
      4'd7: seg_o = 7'b111_1000;
      4'd8: seg_o = 7'b000_0000;
      4'd9: seg_o = 7'b001_0000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Kitchen-style mm:ss:cc countdown timer with tick-sampled keys and a blinking alarm LED.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic               clk,
  input  logic               key_reset,
  input  logic               key_start_pause,
  input  logic               key_load,
  input  logic [COUNT_W-1:0] preset,
  output logic [SEG_W-1:0]   hex0,
  output logic [SEG_W-1:0]   hex1,
  output logic [SEG_W-1:0]   hex2,
  output logic [SEG_W-1:0]   hex3,
  output logic [SEG_W-1:0]   hex4,
  output logic [SEG_W-1:0]   hex5,
  output logic [SEG_W-1:0]   hex6,
  output logic [SEG_W-1:0]   hex7,
  output logic               led0,
  output logic               led1,
  output logic               led2
);

  localparam int unsigned TICK_W  = $clog2(TICK_DIV + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0] blink_q;
  logic [COUNT_W-1:0] count_q;
  state_e             state_q;
  logic               start_q, load_q;
  logic               led0_q, led1_q, led2_q;

  logic               tick;
  logic               start_press, load_press;
  logic               count_zero;
  logic [COUNT_W-1:0] count_run;
  logic [COUNT_W-1:0] preset_clamped;

  // Free-running 10 ms timebase
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  // Rising edge between consecutive tick samples acts as the debounce
  assign start_press    = tick && key_start_pause && !start_q;
  assign load_press     = tick && key_load && !load_q;
  assign count_zero     = (count_q == '0);
  assign count_run      = count_zero ? '0 : bcd_dec(count_q);
  assign preset_clamped = clamp_preset(preset);

  always_ff @(posedge clk) begin
    if (key_reset) begin
      tick_cnt_q <= '0;
      start_q    <= 1'b0;
      load_q     <= 1'b0;
      state_q    <= ST_IDLE;
      count_q    <= '0;
      blink_q    <= '0;
      led0_q     <= 1'b0;
      led1_q     <= 1'b0;
      led2_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      if (tick) begin
        start_q <= key_start_pause;
        load_q  <= key_load;
        case (state_q)
          ST_IDLE: begin
            if (load_press) begin
              count_q <= preset_clamped;
            end else if (start_press && !count_zero) begin
              state_q <= ST_RUN;
              led0_q  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (start_press) begin
              state_q <= ST_PAUSE;
              led0_q  <= 1'b0;
              led1_q  <= 1'b1;
            end else begin
              count_q <= count_run;
              if (count_run == '0) begin
                state_q <= ST_DONE;
                led0_q  <= 1'b0;
                led2_q  <= 1'b1;
                blink_q <= '0;
              end
            end
          end
          ST_PAUSE: begin
            if (load_press) begin
              count_q <= preset_clamped;
              state_q <= ST_IDLE;
              led1_q  <= 1'b0;
            end else if (start_press) begin
              state_q <= ST_RUN;
              led1_q  <= 1'b0;
              led0_q  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (start_press || load_press) begin
              count_q <= preset_clamped;
              state_q <= ST_IDLE;
              led2_q  <= 1'b0;
              blink_q <= '0;
            end else if (blink_q == BLINK_LAST) begin
              blink_q <= '0;
              led2_q  <= !led2_q;
            end else begin
              blink_q <= blink_q + BLINK_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            led0_q  <= 1'b0;
            led1_q  <= 1'b0;
            led2_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led0 = led0_q;
  assign led1 = led1_q;
  assign led2 = led2_q;
  assign hex6 = SEG_BLANK;
  assign hex7 = SEG_BLANK;

  countdown_timer_sevenseg u_seg0 (.bcd_i(count_q[3:0]),   .seg_o(hex0));
  countdown_timer_sevenseg u_seg1 (.bcd_i(count_q[7:4]),   .seg_o(hex1));
  countdown_timer_sevenseg u_seg2 (.bcd_i(count_q[11:8]),  .seg_o(hex2));
  countdown_timer_sevenseg u_seg3 (.bcd_i(count_q[15:12]), .seg_o(hex3));
  countdown_timer_sevenseg u_seg4 (.bcd_i(count_q[19:16]), .seg_o(hex4));
  countdown_timer_sevenseg u_seg5 (.bcd_i(count_q[23:20]), .seg_o(hex5));

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with a 4-cycle tick and 2-tick blink.
module tb_countdown_timer;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        key_reset, key_start_pause, key_load;
  logic [23:0] preset;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        led0, led1, led2;

  typedef struct {
    logic        start;
    logic        load;
    logic [23:0] preset;
    logic [2:0]  leds;
    logic [23:0] count;
  } vec_t;

  typedef struct {
    logic [2:0]  leds;
    logic [41:0] hex;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  countdown_timer #(.TICK_DIV(TD), .BLINK_TICKS(2)) dut (
    .clk(clk), .key_reset(key_reset), .key_start_pause(key_start_pause),
    .key_load(key_load), .preset(preset),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
    .led0(led0), .led1(led1), .led2(led2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b100_0000;
      4'd1: return 7'b111_1001;
      4'd2: return 7'b010_0100;
      4'd3: return 7'b011_0000;
      4'd4: return 7'b001_1001;
      4'd5: return 7'b001_0010;
      4'd6: return 7'b000_0010;
      4'd7: return 7'b111_1000;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b001_0000;
      default: return 7'b111_1111;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] c);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = seg_of(c[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [41:0] act_hex();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic l, input logic [23:0] p,
                     input logic [2:0] leds, input logic [23:0] cnt);
    vec_t v;
    v.start = s; v.load = l; v.preset = p; v.leds = leds; v.count = cnt;
    vecs.push_back(v);
  endtask

  task automatic do_tick();
    repeat (TD) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic l, input logic [23:0] p);
    key_start_pause = s;
    key_load        = l;
    preset          = p;
    do_tick();
  endtask

  initial begin
    exp_t e;
    key_reset       = 1'b1;
    key_start_pause = 1'b0;
    key_load        = 1'b0;
    preset          = '0;
    repeat (3) @(posedge clk);
    #1;
    key_reset = 1'b0;

    check("reset leds", 64'({led2, led1, led0}), 64'(3'b000));
    check("reset hex", 64'(act_hex()), 64'(exp_hex(24'h00_00_00)));
    check("reset hex67", 64'({hex7, hex6}), 64'(14'h3FFF));

    // {start, load, preset, expected {led2,led1,led0}, expected count}
    add(0, 0, 24'h000000, 3'b000, 24'h000000);
    add(0, 1, 24'hFFFFFF, 3'b000, 24'h595999);
    add(0, 0, 24'h000000, 3'b000, 24'h595999);
    add(0, 1, 24'h000000, 3'b000, 24'h000000);
    add(0, 0, 24'h000000, 3'b000, 24'h000000);
    add(1, 0, 24'h000000, 3'b000, 24'h000000);
    add(0, 0, 24'h000000, 3'b000, 24'h000000);
    add(0, 1, 24'h000005, 3'b000, 24'h000005);
    add(0, 0, 24'h000000, 3'b000, 24'h000005);
    add(1, 0, 24'h000000, 3'b001, 24'h000005);
    add(0, 0, 24'h000000, 3'b001, 24'h000004);
    add(0, 0, 24'h000000, 3'b001, 24'h000003);
    add(0, 0, 24'h000000, 3'b001, 24'h000002);
    add(0, 0, 24'h000000, 3'b001, 24'h000001);
    add(0, 0, 24'h000000, 3'b100, 24'h000000);
    add(0, 0, 24'h000000, 3'b100, 24'h000000);
    add(0, 0, 24'h000000, 3'b000, 24'h000000);
    add(0, 0, 24'h000000, 3'b000, 24'h000000);
    add(0, 0, 24'h000000, 3'b100, 24'h000000);
    add(1, 0, 24'h010000, 3'b000, 24'h010000);
    add(0, 0, 24'h000000, 3'b000, 24'h010000);
    add(1, 0, 24'h000000, 3'b001, 24'h010000);
    add(0, 0, 24'h000000, 3'b001, 24'h005999);
    add(1, 0, 24'h000000, 3'b010, 24'h005999);
    for (int k = 0; k < 10; k++) add(0, 0, 24'h000000, 3'b010, 24'h005999);
    add(1, 0, 24'h000000, 3'b001, 24'h005999);
    add(0, 0, 24'h000000, 3'b001, 24'h005998);
    add(1, 0, 24'h000000, 3'b010, 24'h005998);
    add(0, 0, 24'h000000, 3'b010, 24'h005998);
    add(1, 1, 24'h123456, 3'b000, 24'h123456);
    add(0, 0, 24'h000000, 3'b000, 24'h123456);
    add(1, 0, 24'h000000, 3'b001, 24'h123456);
    add(0, 0, 24'h000000, 3'b001, 24'h123455);
    add(1, 1, 24'h000000, 3'b010, 24'h123455);
    add(0, 0, 24'h000000, 3'b010, 24'h123455);
    add(0, 1, 24'h7A6CD3, 3'b000, 24'h595993);
    add(0, 0, 24'h000000, 3'b000, 24'h595993);
    add(1, 1, 24'h000010, 3'b000, 24'h000010);
    add(0, 0, 24'h000000, 3'b000, 24'h000010);
    add(1, 0, 24'h000000, 3'b001, 24'h000010);
    add(1, 0, 24'h000000, 3'b001, 24'h000009);
    add(0, 0, 24'h000000, 3'b001, 24'h000008);

    for (int i = 0; i < vecs.size(); i++) begin
      e.leds = vecs[i].leds;
      e.hex  = exp_hex(vecs[i].count);
      e.idx  = i;
      sb.push_back(e);
      step(vecs[i].start, vecs[i].load, vecs[i].preset);
      e = sb.pop_front();
      check($sformatf("vec%0d leds", e.idx), 64'({led2, led1, led0}), 64'(e.leds));
      check($sformatf("vec%0d hex", e.idx), 64'(act_hex()), 64'(e.hex));
      check($sformatf("vec%0d hex67", e.idx), 64'({hex7, hex6}), 64'(14'h3FFF));
    end

    // Reset pulse between ticks while running at 00:00:08
    key_start_pause = 1'b0;
    key_load        = 1'b0;
    @(posedge clk);
    #1;
    check("prereset hex", 64'(act_hex()), 64'(exp_hex(24'h000008)));
    key_reset = 1'b1;
    @(posedge clk);
    #1;
    key_reset = 1'b0;
    check("midrun reset leds", 64'({led2, led1, led0}), 64'(3'b000));
    check("midrun reset hex", 64'(act_hex()), 64'(exp_hex(24'h000000)));
    do_tick();
    check("post reset idle leds", 64'({led2, led1, led0}), 64'(3'b000));
    check("post reset idle hex", 64'(act_hex()), 64'(exp_hex(24'h000000)));

    // Short run to DONE, then a load press leaves the alarm and reloads
    step(0, 1, 24'h000002);
    step(0, 0, 24'h000000);
    step(1, 0, 24'h000000);
    check("seq run leds", 64'({led2, led1, led0}), 64'(3'b001));
    step(0, 0, 24'h000000);
    check("seq 1cs hex", 64'(act_hex()), 64'(exp_hex(24'h000001)));
    step(0, 0, 24'h000000);
    check("seq done leds", 64'({led2, led1, led0}), 64'(3'b100));
    check("seq done hex", 64'(act_hex()), 64'(exp_hex(24'h000000)));
    step(0, 1, 24'h000300);
    check("seq done load leds", 64'({led2, led1, led0}), 64'(3'b000));
    check("seq done load hex", 64'(act_hex()), 64'(exp_hex(24'h000300)));
    step(1, 0, 24'h000000);
    step(0, 0, 24'h000000);
    check("seq sec borrow hex", 64'(act_hex()), 64'(exp_hex(24'h000299)));
    check("seq sec borrow leds", 64'({led2, led1, led0}), 64'(3'b001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
